tt_pfd: RTL

//  Digital phase-frequency detector at the input of the PLL loop filter (tt_lpf).

---
 rtl/tt_pll_pkg.sv | 17 +
 rtl/tt_sync_edge.sv | 25 ++
 rtl/tt_pfd.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tt_pll_pkg.sv
// Shared types and default sizes for the PLL front end (phase detector and loop filter).
package tt_pll_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } pfd_state_e;

   localparam int PFD_DIV_W_DEF    = 8;
   localparam int PFD_PULSE_W_DEF  = 8;
   localparam int PFD_LOCK_CNT_DEF = 16;

   // div_cnt followed by lock_cnt on the scan chain
   localparam int PFD_SCAN_LEN = PFD_DIV_W_DEF + $clog2(PFD_LOCK_CNT_DEF + 1);

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchronizer for an asynchronous clock-like input, followed by a
// single-cycle rising-edge pulse.
module tt_sync_edge (
   input  logic i_clk_gen,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise
);

   // [0],[1] synchronizer stages, [2] previous synchronized value
   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], i_async};
   end

   always_ff @(posedge i_clk_gen or posedge i_rst) begin
      if (i_rst) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign o_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tt_pfd.sv
// Phase-frequency detector feeding tt_lpf: up/down pulses from ref vs divided fb,
// lock detection, and div_cnt/lock_cnt exposed on a shift chain.
//
//   state | meaning
//   IDLE  | waiting for the next ref or divided fb edge
//   UP    | ref seen first, o_up high until fb edge or timeout
//   DOWN  | fb seen first, o_down high until ref edge or timeout
module tt_pfd
   import tt_pll_pkg::*;
#(
   parameter int DIV_W     = PFD_DIV_W_DEF,
   parameter int PULSE_W   = PFD_PULSE_W_DEF,
   parameter int PULSE_MAX = 200,
   parameter int LOCK_TOL  = 2,
   parameter int LOCK_CNT  = PFD_LOCK_CNT_DEF,
   parameter int LOCK_W    = $clog2(LOCK_CNT + 1)
) (
   input  logic             i_clk_gen,
   input  logic             i_rst,
   input  logic             i_ref,
   input  logic             i_fb,
   input  logic [DIV_W-1:0] i_div_ratio,
   output logic             o_up,
   output logic             o_down,
   output logic             o_locked,
   input  logic             i_scan_en,
   input  logic             i_scan_in,
   output logic             o_scan_out
);

   pfd_state_e          state_q, state_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [PULSE_W-1:0]  pulse_cnt_q, pulse_cnt_d;
   logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic                locked_q, locked_d;

   logic                ref_rise, fb_rise;
   logic [DIV_W-1:0]    ratio_m1;
   logic                fb_wrap, fb_edge;
   logic                end_pulse, timeout, score, aligned;

   tt_sync_edge u_sync_ref (
      .i_clk_gen (i_clk_gen),
      .i_rst     (i_rst),
      .i_async   (i_ref),
      .o_rise    (ref_rise)
   );

   tt_sync_edge u_sync_fb (
      .i_clk_gen (i_clk_gen),
      .i_rst     (i_rst),
      .i_async   (i_fb),
      .o_rise    (fb_rise)
   );

   // >= rather than == so a ratio lowered below the running count wraps at once
   assign ratio_m1 = (i_div_ratio == '0) ? '0 : i_div_ratio - 1'b1;
   assign fb_wrap  = (div_cnt_q >= ratio_m1);
   assign fb_edge  = fb_rise & fb_wrap;

   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      lock_cnt_d  = lock_cnt_q;
      end_pulse   = 1'b0;
      timeout     = 1'b0;
      score       = 1'b0;
      aligned     = 1'b0;

      if (i_scan_en) begin
         state_d     = IDLE;
         pulse_cnt_d = '0;
         div_cnt_d   = {div_cnt_q[DIV_W-2:0], i_scan_in};
         lock_cnt_d  = {lock_cnt_q[LOCK_W-2:0], div_cnt_q[DIV_W-1]};
      end else begin
         if (fb_rise) div_cnt_d = fb_wrap ? '0 : div_cnt_q + 1'b1;

         case (state_q)
            IDLE: begin
               pulse_cnt_d = '0;
               if (ref_rise && fb_edge) begin
                  score   = 1'b1;
                  aligned = 1'b1;
               end else if (ref_rise) begin
                  state_d = UP;
               end else if (fb_edge) begin
                  state_d = DOWN;
               end
            end
            UP, DOWN: begin
               end_pulse   = (state_q == UP) ? fb_edge : ref_rise;
               timeout     = (pulse_cnt_q == PULSE_W'(PULSE_MAX - 1));
               pulse_cnt_d = (&pulse_cnt_q) ? pulse_cnt_q : pulse_cnt_q + 1'b1;
               if (end_pulse || timeout) begin
                  state_d     = IDLE;
                  pulse_cnt_d = '0;
                  score       = 1'b1;
                  // width is pulse_cnt_q + 1 cycles
                  aligned     = !timeout && (pulse_cnt_q < PULSE_W'(LOCK_TOL));
               end
            end
            default: begin
               state_d     = IDLE;
               pulse_cnt_d = '0;
            end
         endcase

         if (score) begin
            if (!aligned)                               lock_cnt_d = '0;
            else if (lock_cnt_q >= LOCK_W'(LOCK_CNT))   lock_cnt_d = LOCK_W'(LOCK_CNT);
            else                                        lock_cnt_d = lock_cnt_q + 1'b1;
         end
      end

      locked_d = (lock_cnt_d == LOCK_W'(LOCK_CNT));
   end

   always_ff @(posedge i_clk_gen or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         div_cnt_q   <= '0;
         pulse_cnt_q <= '0;
         lock_cnt_q  <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         locked_q    <= locked_d;
      end
   end

   // scan gating keeps the filter inputs quiet in the first shift cycle too
   assign o_up       = (state_q == UP)   & ~i_scan_en;
   assign o_down     = (state_q == DOWN) & ~i_scan_en;
   assign o_locked   = locked_q;
   assign o_scan_out = lock_cnt_q[LOCK_W-1];

endmodule
